mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle main control sequencer driving the MIPS datapath's control inputs, replacing the hand-driven control vectors used in datapath-level benches. Each cycle it consumes the opcode, funct and zero flag the datapath returns, steps a FETCH/DECODE/EXEC/MEM/WB state machine, and emits the datapath control word plus a PC-update strobe and instruction-register load. Data-memory accesses use a ready handshake so slow memories stall the sequencer.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Opcode` in 6: instruction[31:26] from the datapath.
- `Funct` in 6: instruction[5:0].
- `Is0` in 1: ALU zero flag, combinational from the datapath.
- `MemReady` in 1: data memory completes the current access this cycle.
- `RegDst`, `RegWrite`, `ALUSrc`, `MemWrite`, `MemRead`, `MemToReg`, `JumpPC` out 1 each: datapath controls.
- `PCSrc` out 1: branch-taken select.
- `ALUcontrol` out 4: ALU operation.
- `PCEn` out 1: PC update strobe, one cycle per retired instruction.
- `IRWrite` out 1: latch instruction memory output.
- `Illegal` out 1: sticky, unsupported opcode/funct.
- `InstrCount` out CNT_W: retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: IRWrite=1 → DECODE.
- DECODE: `Opcode`/`Funct` are latched internally. Supported ops go to EXEC; anything else goes to TRAP.
- Supported opcodes:
  - R-type 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- ALUcontrol encodings: add 0101, sub 0110, and 0000, or 0001, slt 0111. lw/sw/addi use add; beq uses sub.
- EXEC, per op:
  - R-type: ALUSrc=0, RegDst=1 → WB.
  - addi/lw/sw: ALUSrc=1 → WB (addi) or MEM (lw/sw).
  - beq: PCSrc=Is0, PCEn=1 → FETCH.
  - j: JumpPC=1, PCEn=1 → FETCH.
- MEM:
  - lw: MemRead=1 held until MemReady, then → WB.
  - sw: MemWrite=1 held until MemReady; on that cycle PCEn=1 → FETCH.
- WB: RegWrite=1 and PCEn=1 → FETCH.
  - R-type: RegDst=1, MemToReg=0.
  - addi: RegDst=0, MemToReg=0.
  - lw: RegDst=0, MemToReg=1.
- TRAP: Illegal=1; all other controls 0; held until Reset.
- InstrCount increments on every PCEn cycle and wraps modulo 2^CNT_W.
- Any control not listed for a state is 0 in that state.

## Timing
- All outputs except PCSrc are registered, computed from next state, so they are valid the cycle a state is entered.
- PCSrc is combinational: (state==EXEC & latched op==beq & Is0).
- Reset values: all outputs 0, ALUcontrol 0000, InstrCount 0, state FETCH. The first cycle after Reset release is FETCH with IRWrite=1.
- Cycles per instruction, with MemReady asserted on the first MEM cycle:
  - beq, j: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
  - Each MemReady-low cycle adds 1.
- MemReady is sampled only in MEM and ignored elsewhere.
- MemRead/MemWrite are never both 1.
- Reset during MEM drops MemWrite/MemRead asynchronously, with no PCEn and no count.
- Opcode/Funct changing after DECODE has no effect.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct constants.
  - ALUcontrol encodings.
  - state enum.
  - control-word struct {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JumpPC, ALUcontrol}.
- Sub-module `mips_alu_decode`: combinational latched op/funct → ALUcontrol, reused by future pipelined control.

## Test plan
- Reset mid-MEM of sw with MemReady=0: MemWrite falls within the reset assertion; after release, outputs are 0 and IRWrite=1 next cycle; InstrCount=0.
- R-type add (000000/100000) → ALUcontrol 0101, RegDst=1 in EXEC and WB; RegWrite and PCEn both 1 only in cycle 4; InstrCount 0→1.
- lw with MemReady low for 2 MEM cycles → MemRead=1 for 3 cycles; WB with MemToReg=1, RegWrite=1; 7 cycles total.
- beq with Is0=1 then Is0=0 → PCSrc=1 and 0 respectively in EXEC with ALUcontrol 0110; PCEn once each; RegWrite never asserted.
- Opcode 111111 → TRAP, Illegal=1 sticky, PCEn stays 0 for 20 cycles, InstrCount frozen.
- CNT_W=4, 16 j instructions → InstrCount wraps 15→0; JumpPC=1 only in EXEC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU encodings, sequencer state and control word
// for the MIPS control blocks.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       jump_pc;
    logic [3:0] alu_control;
  } ctrl_t;

  // True for every opcode/funct pair the sequencer knows how to run.
  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational opcode/funct to ALU operation decode.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  // R-type selects by funct; memory ops and addi add, beq subtracts.
  always_comb begin
    alu_control = ALU_AND;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_AND;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_control = ALU_ADD;
      OP_BEQ:                alu_control = ALU_SUB;
      default:               alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS datapath.
// Controls are registered from the next state so they are valid on state entry.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Is0,
  input  logic             MemReady,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemToReg,
  output logic             JumpPC,
  output logic             PCSrc,
  output logic [3:0]       ALUcontrol,
  output logic             PCEn,
  output logic             IRWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_q, state_d;
  logic             started_q;
  logic [5:0]       op_q, funct_q, op_eff, funct_eff;
  logic [3:0]       alu_dec;
  ctrl_t            ctrl_q, ctrl_d;
  logic             pcen_q, pcen_d, irw_q, irw_d, ill_q, ill_d;
  logic             sw_done;
  logic [CNT_W-1:0] cnt_q;

  // In DECODE the op is still on the inputs; afterwards only the latched copy counts.
  always_comb begin
    op_eff    = (state_q == S_DECODE) ? Opcode : op_q;
    funct_eff = (state_q == S_DECODE) ? Funct  : funct_q;
  end

  mips_alu_decode u_alu_decode (
    .op          (op_eff),
    .funct       (funct_eff),
    .alu_control (alu_dec)
  );

  // Next-state selection. The first cycle out of reset re-enters FETCH so
  // IRWrite can be raised while every output still reads 0 during reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = started_q ? S_DECODE : S_FETCH;
      S_DECODE: state_d = is_supported(Opcode, Funct) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          OP_BEQ, OP_J: state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:    if (MemReady) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control word for the state about to be entered.
  always_comb begin
    ctrl_d = '0;
    pcen_d = 1'b0;
    irw_d  = 1'b0;
    ill_d  = 1'b0;
    case (state_d)
      S_FETCH: irw_d = 1'b1;
      S_EXEC: begin
        ctrl_d.alu_control = alu_dec;
        case (op_eff)
          OP_RTYPE:             ctrl_d.reg_dst = 1'b1;
          OP_ADDI, OP_LW, OP_SW: ctrl_d.alu_src = 1'b1;
          OP_BEQ:               pcen_d = 1'b1;
          OP_J: begin
            ctrl_d.jump_pc = 1'b1;
            pcen_d         = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_d.mem_read  = (op_eff == OP_LW);
        ctrl_d.mem_write = (op_eff == OP_SW);
      end
      S_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = (op_eff == OP_RTYPE);
        ctrl_d.mem_to_reg = (op_eff == OP_LW);
        pcen_d            = 1'b1;
      end
      S_TRAP: ill_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched instruction fields and registered controls.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      op_q      <= '0;
      funct_q   <= '0;
      ctrl_q    <= '0;
      pcen_q    <= 1'b0;
      irw_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (state_q == S_DECODE) begin
        op_q    <= Opcode;
        funct_q <= Funct;
      end
      ctrl_q <= ctrl_d;
      pcen_q <= pcen_d;
      irw_q  <= irw_d;
      ill_q  <= ill_d;
    end
  end

  // A store retires in the MEM cycle that MemReady arrives, which a registered
  // strobe cannot see in time, so that one PCEn term is taken combinationally.
  assign sw_done = (state_q == S_MEM) && (op_q == OP_SW) && MemReady;

  // Retired-instruction counter, one step per PCEn cycle, wraps naturally.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else if (PCEn) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign RegDst     = ctrl_q.reg_dst;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUSrc     = ctrl_q.alu_src;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemRead    = ctrl_q.mem_read;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign JumpPC     = ctrl_q.jump_pc;
  assign ALUcontrol = ctrl_q.alu_control;
  assign PCSrc      = (state_q == S_EXEC) && (op_q == OP_BEQ) && Is0;
  assign PCEn       = pcen_q | sw_done;
  assign IRWrite    = irw_q;
  assign Illegal    = ill_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected control words are queued
// as each instruction is scheduled and compared as the sequencer steps.
module tb_mips_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, Funct;
  logic       Is0, MemReady;
  logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JumpPC, PCSrc;
  logic [3:0] ALUcontrol;
  logic       PCEn, IRWrite, Illegal;
  logic [3:0] InstrCount;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Is0(Is0),
    .MemReady(MemReady), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg), .JumpPC(JumpPC),
    .PCSrc(PCSrc), .ALUcontrol(ALUcontrol), .PCEn(PCEn), .IRWrite(IRWrite),
    .Illegal(Illegal), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, jump_pc;
    logic pc_src, pc_en, ir_write, illegal;
    logic [3:0] alu;
  } obs_t;

  typedef enum logic [2:0] {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J} kind_t;

  typedef struct {
    kind_t      kind;
    logic [5:0] op;
    logic [5:0] fn;
    logic       is0;
    int         stalls;
    logic [3:0] alu;
  } vec_t;

  typedef struct {
    obs_t       exp;
    logic [3:0] cnt;
    logic [5:0] op, fn;
    logic       is0, rdy;
  } step_t;

  step_t      sb[$];
  vec_t       tbl[13];
  logic [3:0] cnt_model;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s (step %0d): got %h, want %h", nm, cyc, got, want);
    end
  endtask

  function automatic obs_t sample();
    return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JumpPC,
            PCSrc, PCEn, IRWrite, Illegal, ALUcontrol};
  endfunction

  task automatic push(input obs_t o, input logic [5:0] op, input logic [5:0] fn,
                      input logic is0, input logic rdy);
    step_t s;
    s.exp = o; s.cnt = cnt_model; s.op = op; s.fn = fn; s.is0 = is0; s.rdy = rdy;
    sb.push_back(s);
    if (o.pc_en) cnt_model = cnt_model + 4'd1;
  endtask

  // Expected cycle-by-cycle controls for one instruction; opcode is scrambled
  // after DECODE to show the latched copy is what matters.
  task automatic sched(input vec_t v);
    obs_t o;
    o = '0; o.ir_write = 1'b1;
    push(o, v.op, v.fn, v.is0, 1'b1);
    o = '0;
    push(o, v.op, v.fn, v.is0, 1'b1);
    o = '0; o.alu = v.alu;
    case (v.kind)
      K_R:               o.reg_dst = 1'b1;
      K_ADDI, K_LW, K_SW: o.alu_src = 1'b1;
      K_BEQ: begin o.pc_en = 1'b1; o.pc_src = v.is0; end
      K_J:   begin o.pc_en = 1'b1; o.jump_pc = 1'b1; end
      default: ;
    endcase
    push(o, ~v.op, ~v.fn, v.is0, 1'b1);
    if (v.kind == K_LW || v.kind == K_SW) begin
      for (int s = 0; s <= v.stalls; s++) begin
        o = '0;
        o.mem_read  = (v.kind == K_LW);
        o.mem_write = (v.kind == K_SW);
        o.pc_en     = (v.kind == K_SW) && (s == v.stalls);
        push(o, ~v.op, ~v.fn, v.is0, s == v.stalls);
      end
    end
    if (v.kind == K_R || v.kind == K_ADDI || v.kind == K_LW) begin
      o = '0; o.reg_write = 1'b1; o.pc_en = 1'b1;
      o.reg_dst = (v.kind == K_R); o.mem_to_reg = (v.kind == K_LW);
      push(o, ~v.op, ~v.fn, v.is0, 1'b0);
    end
  endtask

  // Pop each expected cycle, drive its inputs, compare once outputs settle.
  task automatic drain();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge CLK);
      Opcode = s.op; Funct = s.fn; Is0 = s.is0; MemReady = s.rdy;
      #1;
      cyc++;
      check("ctrl", 32'(sample()), 32'(s.exp));
      check("count", 32'(InstrCount), 32'(s.cnt));
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    tbl[0]  = '{K_R,    6'b000000, 6'b100000, 1'b1, 0, 4'b0101};
    tbl[1]  = '{K_R,    6'b000000, 6'b100010, 1'b0, 0, 4'b0110};
    tbl[2]  = '{K_R,    6'b000000, 6'b100100, 1'b1, 0, 4'b0000};
    tbl[3]  = '{K_R,    6'b000000, 6'b100101, 1'b0, 0, 4'b0001};
    tbl[4]  = '{K_R,    6'b000000, 6'b101010, 1'b1, 0, 4'b0111};
    tbl[5]  = '{K_ADDI, 6'b001000, 6'b010101, 1'b1, 0, 4'b0101};
    tbl[6]  = '{K_LW,   6'b100011, 6'b000111, 1'b0, 0, 4'b0101};
    tbl[7]  = '{K_LW,   6'b100011, 6'b111000, 1'b1, 2, 4'b0101};
    tbl[8]  = '{K_SW,   6'b101011, 6'b000001, 1'b0, 0, 4'b0101};
    tbl[9]  = '{K_SW,   6'b101011, 6'b100000, 1'b1, 1, 4'b0101};
    tbl[10] = '{K_BEQ,  6'b000100, 6'b001100, 1'b1, 0, 4'b0110};
    tbl[11] = '{K_BEQ,  6'b000100, 6'b001100, 1'b0, 0, 4'b0110};
    tbl[12] = '{K_J,    6'b000010, 6'b100000, 1'b1, 0, 4'b0000};

    Reset = 1'b1; Opcode = '0; Funct = '0; Is0 = 1'b0; MemReady = 1'b0;
    cnt_model = 4'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("reset_outputs", 32'(sample()), 32'd0);
    check("reset_count", 32'(InstrCount), 32'd0);

    foreach (tbl[i]) begin
      sched(tbl[i]);
      drain();
    end

    v = '{K_J, 6'b000010, 6'b000000, 1'b0, 0, 4'b0000};
    for (int i = 0; i < 16; i++) begin
      sched(v);
      drain();
    end

    // Store stalled in MEM, then reset asserted mid-cycle.
    v = '{K_SW, 6'b101011, 6'b000000, 1'b0, 5, 4'b0101};
    sched(v);
    while (sb.size() > 5) void'(sb.pop_back());
    drain();
    @(negedge CLK);
    MemReady = 1'b0;
    #1;
    check("sw_stall_memwrite", 32'(MemWrite), 32'd1);
    check("sw_stall_pcen", 32'(PCEn), 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    check("async_memwrite_drop", 32'(MemWrite), 32'd0);
    check("async_pcen", 32'(PCEn), 32'd0);
    check("async_count", 32'(InstrCount), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("post_reset_outputs", 32'(sample()), 32'd0);
    check("post_reset_count", 32'(InstrCount), 32'd0);
    cnt_model = 4'd0;

    // Unsupported opcode: trap is sticky and freezes the count.
    o = '0; o.ir_write = 1'b1;
    push(o, 6'b111111, 6'b000000, 1'b0, 1'b1);
    o = '0;
    push(o, 6'b111111, 6'b000000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      o = '0; o.illegal = 1'b1;
      push(o, 6'(i * 7), 6'(i * 3), i[0], i[1]);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
